pattern_lock_detector: RTL
==========================

Name: pattern_lock_detector

Overview:
- Parametrised successor to the fixed 8-bit, 4-repeat pattern detector.
- Compares a word-serial input stream against a PatLen-word reference pattern, least-significant word first.
- Declares lock after nRepeat consecutive error-free pattern repetitions, then tracks word errors while locked and drops lock after LossThresh consecutive bad words.
- Sits after the PRBS/pattern generator and checker chain as the receive-side lock monitor.

Parameters:
- BusWidth, 8: input word width in bits.
- PatLen, 4: number of words in one pattern period.
- Pattern, 32'hAABBCCDD: reference pattern, BusWidth*PatLen bits; word k = Pattern[k*BusWidth +: BusWidth]; word 0 is sent first.
- nRepeat, 4: consecutive correct pattern periods required to lock (>=1).
- LossThresh, 2: consecutive mismatching words while locked that cause loss of lock (>=1).
- CntWidth, 16: width of the error counter.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  synchronous reset, active-high.
- InValid  in  1  InData qualifier; logic ignores cycles where it is 0 (state holds).
- InData  in  BusWidth  received word.
- ClrErr  in  1  synchronous clear of ErrCnt.
- Flag  out  1  lock indicator (1 = LOCKED).
- PatMatch  out  1  one-cycle pulse per complete error-free pattern period.
- ErrCnt  out  CntWidth  count of mismatching words while LOCKED, saturating.

Behaviour:
- All outputs are registered. Reset values: Flag=0, PatMatch=0, ErrCnt=0, state=SEARCH, word index=0, repeat count=0, bad-word run=0.
- Reset is synchronous. RST=1 at a clock edge forces the reset values regardless of state, including mid-pattern or while LOCKED.
- Word index idx runs 0..PatLen-1, advances only on InValid, and wraps from PatLen-1 to 0. Expected word = Pattern word idx.
- State SEARCH: on a valid word equal to word 0, set idx=1 and repeat count=0, then go to VERIFY. If PatLen=1, the period completes immediately; see period completion below.
- State VERIFY:
  - A valid word equal to word idx advances idx.
  - A valid mismatching word sets repeat count=0. The same word is then re-checked against word 0: if equal, idx=1 and stay in VERIFY; otherwise go to SEARCH with idx=0.
- Period completion: a match at idx=PatLen-1 completes a period.
  - PatMatch=1 on the next cycle.
  - Repeat count increments. When it reaches nRepeat, go to LOCKED; Flag=1 on the cycle after the last word of the nRepeat-th period is sampled.
- State LOCKED:
  - idx advances on every valid word, match or not, so alignment is kept.
  - A match clears the bad-word run. A complete period with no mismatched word pulses PatMatch.
  - A mismatch increments ErrCnt (saturating at all-ones, no wrap) and increments the bad-word run.
  - When the bad-word run reaches LossThresh: go to SEARCH, Flag=0 on the next cycle, idx=0, repeat count=0, bad-word run=0. ErrCnt is retained.
- ErrCnt changes only in LOCKED. ClrErr=1 zeroes ErrCnt, and clear has priority over a simultaneous increment.
- InValid=0: no state, index, counter or run change. PatMatch is 0 that cycle, and Flag holds.
- Latency: input word to Flag/PatMatch/ErrCnt update is 1 clock.

Test Plan:
- Defaults, InValid=1, RST pulse, then DD,CC,BB,AA repeated 10 times -> PatMatch pulses every 4th cycle; Flag=1 one cycle after the 16th word and stays 1; ErrCnt=0.
- Repeat DD,CC,44,AA ×10 (byte error), then DD,CD,BB,AA ×10 (bit error) -> Flag stays 0, PatMatch never pulses, ErrCnt=0.
- Sequence: one good period, one DD,CD,BB,AA period, three good periods -> Flag=0 (only 3 consecutive). One more good period -> Flag=1.
- Locked, inject a single bad word (BB→BA) -> ErrCnt=1, Flag stays 1, next period gives no PatMatch. Inject two consecutive bad words -> ErrCnt=3, Flag=0 the next cycle. Resume good words -> relock after 4 periods with ErrCnt=3. Assert ClrErr -> ErrCnt=0.
- Locked stream with InValid toggled 0/1 every other cycle -> identical lock and count results, with no change on invalid cycles. Assert RST while locked -> Flag=0 and ErrCnt=0 on the next cycle.
- BusWidth=16, PatLen=3, Pattern=48'h1234_5678_9ABC, nRepeat=2, ErrCnt forced near saturation with CntWidth=2 -> lock after 6 words; ErrCnt saturates at 3.

Source files
------------

// File: rtl/pattern_lock_detector.sv
// pattern_lock_detector
// Receive-side lock monitor placed after the pattern generator and checker chain.
// It compares a word-serial stream against a PatLen-word reference pattern.
// Word 0 is the least-significant word of Pattern and is expected first.
// Lock is declared after nRepeat consecutive clean pattern periods.
// While locked, mismatching words are counted, and lock is dropped after
// LossThresh consecutive bad words.
//
// Ports:
//   CLK      in   1         rising-edge clock
//   RST      in   1         synchronous active-high reset
//   InValid  in   1         qualifies InData; state holds when low
//   InData   in   BusWidth  received word
//   ClrErr   in   1         synchronous clear of ErrCnt (wins over increment)
//   Flag     out  1         1 = LOCKED
//   PatMatch out  1         one-cycle pulse per complete clean pattern period
//   ErrCnt   out  CntWidth  saturating count of bad words seen while LOCKED
module pattern_lock_detector #(
    parameter int BusWidth   = 8,
    parameter int PatLen     = 4,
    parameter logic [BusWidth*PatLen-1:0] Pattern = 32'hAABBCCDD,
    parameter int nRepeat    = 4,
    parameter int LossThresh = 2,
    parameter int CntWidth   = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                InValid,
    input  logic [BusWidth-1:0] InData,
    input  logic                ClrErr,
    output logic                Flag,
    output logic                PatMatch,
    output logic [CntWidth-1:0] ErrCnt
);

    localparam int IDX_W = (PatLen > 1) ? $clog2(PatLen) : 1;
    localparam int REP_W = $clog2(nRepeat + 1);
    localparam int BAD_W = $clog2(LossThresh + 1);

    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(PatLen - 1);
    localparam logic [REP_W-1:0]    REP_ONE  = REP_W'(1);
    localparam logic [REP_W-1:0]    REP_N    = REP_W'(nRepeat);
    localparam logic [BAD_W-1:0]    BAD_ONE  = BAD_W'(1);
    localparam logic [BAD_W-1:0]    BAD_N    = BAD_W'(LossThresh);
    localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);
    localparam logic [CntWidth-1:0] CNT_MAX  = {CntWidth{1'b1}};

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [REP_W-1:0]     rep_r, rep_s;
    logic [BAD_W-1:0]     bad_r, bad_s;
    logic                 clean_r, clean_s;   // no bad word yet in current locked period
    logic                 flag_r;
    logic                 pm_r, pm_s;
    logic [CntWidth-1:0]  err_r, err_s;
    logic                 match_s, first_s, last_s;
    logic [REP_W-1:0]     rep_inc_s;
    logic [BAD_W-1:0]     bad_inc_s;

    // Reference word k of the pattern, word 0 in the least-significant slot.
    function automatic logic [BusWidth-1:0] pat_word(input logic [IDX_W-1:0] k);
        return Pattern[int'(k)*BusWidth +: BusWidth];
    endfunction

    // Next-state, counters and output pulse for the lock FSM.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        rep_s     = rep_r;
        bad_s     = bad_r;
        clean_s   = clean_r;
        pm_s      = 1'b0;
        err_s     = err_r;
        match_s   = (InData == pat_word(idx_r));
        first_s   = (InData == pat_word(IDX_W'(0)));
        last_s    = (idx_r == IDX_LAST);
        rep_inc_s = rep_r + REP_ONE;
        bad_inc_s = bad_r + BAD_ONE;

        if (InValid) begin
            case (state_r)
                ST_SEARCH: begin
                    if (first_s) begin
                        rep_s   = '0;
                        state_s = ST_VERIFY;
                        if (PatLen == 1) begin
                            // A one-word pattern completes a period on word 0 itself.
                            idx_s = '0;
                            pm_s  = 1'b1;
                            if (nRepeat == 1) begin
                                state_s = ST_LOCKED;
                                bad_s   = '0;
                                clean_s = 1'b1;
                            end else begin
                                rep_s = REP_ONE;
                            end
                        end else begin
                            idx_s = IDX_ONE;
                        end
                    end else begin
                        idx_s = '0;
                    end
                end
                ST_VERIFY: begin
                    if (match_s) begin
                        if (last_s) begin
                            idx_s = '0;
                            pm_s  = 1'b1;
                            if (rep_inc_s == REP_N) begin
                                state_s = ST_LOCKED;
                                rep_s   = '0;
                                bad_s   = '0;
                                clean_s = 1'b1;
                            end else begin
                                rep_s = rep_inc_s;
                            end
                        end else begin
                            idx_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        // The bad word may itself be the start of a new period.
                        rep_s = '0;
                        if (first_s) begin
                            idx_s = IDX_ONE;
                        end else begin
                            idx_s   = '0;
                            state_s = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Alignment is kept: the index walks on every valid word.
                    idx_s = last_s ? '0 : (idx_r + IDX_ONE);
                    if (match_s) begin
                        bad_s   = '0;
                        pm_s    = last_s & clean_r;
                        clean_s = last_s ? 1'b1 : clean_r;
                    end else begin
                        err_s   = (err_r == CNT_MAX) ? CNT_MAX : (err_r + CNT_ONE);
                        clean_s = last_s;
                        if (bad_inc_s == BAD_N) begin
                            state_s = ST_SEARCH;
                            idx_s   = '0;
                            rep_s   = '0;
                            bad_s   = '0;
                        end else begin
                            bad_s = bad_inc_s;
                        end
                    end
                end
                default: begin
                    state_s = ST_SEARCH;
                    idx_s   = '0;
                    rep_s   = '0;
                    bad_s   = '0;
                    clean_s = 1'b0;
                end
            endcase
        end else begin
            pm_s = 1'b0;
        end

        if (ClrErr) begin
            err_s = '0;
        end else begin
            err_s = err_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_SEARCH;
            idx_r   <= '0;
            rep_r   <= '0;
            bad_r   <= '0;
            clean_r <= 1'b0;
            flag_r  <= 1'b0;
            pm_r    <= 1'b0;
            err_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            rep_r   <= rep_s;
            bad_r   <= bad_s;
            clean_r <= clean_s;
            flag_r  <= (state_s == ST_LOCKED);
            pm_r    <= pm_s;
            err_r   <= err_s;
        end
    end

    assign Flag     = flag_r;
    assign PatMatch = pm_r;
    assign ErrCnt   = err_r;

endmodule
